// File: rtl/shift_add_mult_8bit.sv
// ---------------------------------------------------------------------------
// shift_add_mult_8bit
//   Sequential unsigned multiplier. Uses shift-and-add with one
//   partial-product step per clock, so a product takes WIDTH RUN cycles.
//   Each step's addition goes through a WIDTH-bit ripple-carry adder
//   (rca_8bit when WIDTH=8).
//
//   Ports:
//     clk    in   1        single clock, rising edge
//     rst    in   1        synchronous active-high reset
//     start  in   1        request, sampled only in IDLE or DONE
//     a      in   WIDTH    multiplicand, captured when start is accepted
//     b      in   WIDTH    multiplier, captured when start is accepted
//     p      out  2*WIDTH  product register, holds the last result
//     busy   out  1        high while in RUN
//     done   out  1        one-cycle pulse when a new p is valid
// ---------------------------------------------------------------------------

module rca_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  // The carry is kept in a scalar that is walked through the bit loop.
  // This describes a true ripple chain without a self-referencing vector.
  always_comb begin
    logic carry;
    sum   = '0;
    carry = cin;
    for (int i = 0; i < 8; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

module shift_add_mult_8bit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] p_q;

  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_sum;
  logic               add_co;
  logic [2*WIDTH-1:0] acc_next;
  logic               last_step;
  logic               accept;

  // The upper half of acc is the running partial sum. The multiplicand is
  // added in only when the multiplier bit currently in acc[0] is set.
  assign add_a = acc[2*WIDTH-1:WIDTH];
  assign add_b = acc[0] ? mcand : '0;

  generate
    if (WIDTH == 8) begin : g_rca
      rca_8bit u_rca (
        .a    (add_a),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_co)
      );
    end else begin : g_generic_add
      assign {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b};
    end
  endgenerate

  // The carry-out re-enters at the MSB while the whole register shifts
  // right. This retires one multiplier bit per step and never loses the
  // carry.
  assign acc_next  = {add_co, add_sum, acc[WIDTH-1:1]};
  assign last_step = (cnt == CW'(WIDTH - 1));
  assign accept    = start && ((state_q == IDLE) || (state_q == DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      p_q   <= '0;
    end else if (accept) begin
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
      cnt   <= '0;
    end else if (state_q == RUN) begin
      acc <= acc_next;
      cnt <= cnt + CW'(1);
      if (last_step) begin
        p_q <= acc_next;
      end
    end
  end

  assign p    = p_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_shift_add_mult_8bit.sv
// ---------------------------------------------------------------------------
// tb_shift_add_mult_8bit
//   Directed self-checking bench for shift_add_mult_8bit with WIDTH=8.
//   The expected products were worked out by hand. A random sweep compares
//   each result against a*b.
// ---------------------------------------------------------------------------

module tb_shift_add_mult_8bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] p;
  logic        busy;
  logic        done;

  int          checkCount;
  int          failCount;
  logic [15:0] lastP;

  shift_add_mult_8bit #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .p     (p),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One full operation: the accept edge, then 8 RUN cycles, then DONE and
  // the return to IDLE. If pokeAt >= 0, start is raised with 7*7 for one
  // edge during RUN, and it must be ignored.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                               input logic [15:0] expP, input string tag,
                               input int pokeAt = -1);
    logic runOk;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~av; b = ~bv;
    runOk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        if (i == pokeAt) begin
          @(negedge clk);
          start = 1'b1; a = 8'd7; b = 8'd7;
        end
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (busy !== 1'b1 || done !== 1'b0 || p !== lastP) runOk = 1'b0;
    end
    checkOutput({tag, "/run"}, {31'd0, runOk}, 32'd1);
    @(posedge clk); #1;
    checkOutput({tag, "/done"}, {30'd0, busy, done}, 32'b01);
    checkOutput({tag, "/p"}, {16'd0, p}, {16'd0, expP});
    lastP = expP;
    @(posedge clk); #1;
    checkOutput({tag, "/idle"}, {15'd0, p, busy, done}, {15'd0, expP, 2'b00});
  endtask

  initial begin
    logic       quietOk;
    logic [7:0] ra;
    logic [7:0] rb;
    checkCount = 0;
    failCount  = 0;
    lastP      = 16'h0000;
    rst = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", {15'd0, p, busy, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(8'd13, 8'd11, 16'h008F, "13x11");

    // Reset during RUN step 4 of 0xFF*0xFF discards the operation.
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("midrun/busy", {31'd0, busy}, 32'd1);
    checkOutput("midrun/pHold", {16'd0, p}, 32'h008F);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrun/reset", {15'd0, p, busy, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    lastP = 16'h0000;
    applyStimulus(8'd6, 8'd7, 16'h002A, "6x7");

    applyStimulus(8'hFF, 8'hFF, 16'hFE01, "ffxff");
    applyStimulus(8'h80, 8'h02, 16'h0100, "80x02");
    applyStimulus(8'h00, 8'hA5, 16'h0000, "00xa5");
    applyStimulus(8'h01, 8'hFF, 16'h00FF, "01xff");

    // A start during RUN must not restart the operation or queue a second.
    applyStimulus(8'd3, 8'd5, 16'h000F, "ignore", 3);
    quietOk = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || p !== 16'h000F) quietOk = 1'b0;
    end
    checkOutput("ignore/noSecondDone", {31'd0, quietOk}, 32'd1);

    // Start held high gives back-to-back operations with one done every 9 edges.
    @(negedge clk);
    a = 8'd2; b = 8'd9; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 26; k++) begin
      @(posedge clk); #1;
      if ((k % 9) == 8) begin
        checkOutput($sformatf("b2b/done%0d", k), {15'd0, p, busy, done},
                    {15'd0, 16'h0012, 2'b01});
      end else begin
        checkOutput($sformatf("b2b/busy%0d", k), {30'd0, busy, done}, 32'b10);
      end
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("b2b/stop", {30'd0, busy, done}, 32'b00);
    lastP = 16'h0012;

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      applyStimulus(ra, rb, 16'(ra) * 16'(rb), $sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", checkCount, failCount);
    $finish;
  end

endmodule
